// File: rtl/program_loader_pkg.sv
// Shared definitions for stream-to-memory loaders: FSM states and
// frame layout constants.
package program_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    localparam int BYTE_W = 8;

    // A zero header byte stands for the largest frame the memory holds.
    localparam logic [BYTE_W-1:0] HDR_MAX_WORDS = 8'h00;

    function automatic int bytes_per_word(input int word_w);
        return word_w / BYTE_W;
    endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// Shifts stream bytes MSB-first into a word and pulses word_valid
// for one cycle after the final byte of each word.
module word_assembler
    import program_loader_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              shift,
    input  logic [BYTE_W-1:0] data,
    output logic              word_end,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    localparam int BPW = bytes_per_word(WORD_W);
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BPW - 1);

    logic [CNT_W-1:0] cnt;

    assign word_end = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                cnt <= '0;
            end else if (shift) begin
                word <= (word << BYTE_W) | WORD_W'(data);
                if (word_end) begin
                    cnt        <= '0;
                    word_valid <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a checksummed instruction frame into instruction memory,
// then runs the CPU until it traps.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    input  logic              trap,
    output logic              run,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = ADDR_W + 1;

    logic [1:0]        rst_sync;
    logic              rst_i;
    state_t            state;
    state_t            nxt;
    logic [CNT_W-1:0]  words_left;
    logic [CNT_W-1:0]  hdr_words;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        csum;
    logic              err_q;
    logic              done_q;
    logic              xfer;
    logic              load_hdr;
    logic              take_byte;
    logic              set_err;
    logic              word_end;
    logic              word_valid;
    logic [WORD_W-1:0] word;

    // Assert asynchronously, release two edges later in step with clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_i = rst_sync[1];

    assign in_ready   = (state != S_RUN);
    assign xfer       = in_valid && in_ready;
    assign run        = (state == S_RUN);
    assign done       = done_q;
    assign err        = err_q;
    assign imem_we    = word_valid;
    assign imem_addr  = addr;
    assign imem_wdata = word;

    always_comb begin
        if (in_data == HDR_MAX_WORDS) hdr_words = {1'b1, {ADDR_W{1'b0}}};
        else                          hdr_words = CNT_W'(in_data);
    end

    always_comb begin
        nxt       = state;
        load_hdr  = 1'b0;
        take_byte = 1'b0;
        set_err   = 1'b0;
        unique case (state)
            S_IDLE, S_ERR: begin
                if (xfer) begin
                    load_hdr = 1'b1;
                    nxt      = S_LOAD;
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    take_byte = 1'b1;
                    if (word_end && words_left == CNT_W'(1)) nxt = S_CSUM;
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    if (in_data == csum) begin
                        nxt = S_RUN;
                    end else begin
                        nxt     = S_ERR;
                        set_err = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (trap) nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state      <= S_IDLE;
            words_left <= '0;
            addr       <= '0;
            csum       <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state  <= nxt;
            done_q <= (state == S_RUN) && trap;
            if (load_hdr) begin
                words_left <= hdr_words;
                addr       <= '0;
                csum       <= '0;
                err_q      <= 1'b0;
            end else begin
                if (take_byte) csum <= csum ^ in_data;
                if (take_byte && word_end) words_left <= words_left - 1'b1;
                if (word_valid) addr <= addr + 1'b1;
                if (set_err) err_q <= 1'b1;
            end
        end
    end

    word_assembler #(
        .WORD_W(WORD_W)
    ) u_asm (
        .clk       (clk),
        .rst_n     (rst_i),
        .clear     (load_hdr),
        .shift     (take_byte),
        .data      (in_data),
        .word_end  (word_end),
        .word_valid(word_valid),
        .word      (word)
    );

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized frames against a word-list/XOR reference
// model of the loader.
module tb_program_loader;

    localparam int AW = 2;
    localparam int WW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [WW-1:0] imem_wdata;
    logic          trap = 1'b0;
    logic          run;
    logic          done;
    logic          err;

    int checks = 0;
    int passed = 0;
    int timeouts = 0;
    int stalls = 0;
    int we_count = 0;
    int we0;

    logic [AW-1:0] got_addr[$];
    logic [31:0]   got_data[$];
    logic [31:0]   words[$];

    always #5 clk = ~clk;

    program_loader #(.ADDR_W(AW), .WORD_W(WW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .trap      (trap),
        .run       (run),
        .done      (done),
        .err       (err)
    );

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            we_count++;
            got_addr.push_back(imem_addr);
            got_data.push_back(imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = b;
        while (1) begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            stalls++;
            n++;
            if (n > 50) begin
                timeouts++;
                break;
            end
        end
        tick();
        in_valid = 1'b0;
    endtask

    function automatic int pick_gap(input int maxgap);
        return (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    endfunction

    // Data bytes and checksum; model: word i lands at i mod 2^AW,
    // frame succeeds iff checksum equals XOR of data bytes.
    task automatic body(input logic [7:0] cdelta, input int maxgap,
                        input string tag);
        logic [7:0] x = 8'h00;
        logic [7:0] b;
        int s0 = stalls;
        got_addr.delete();
        got_data.delete();
        foreach (words[i]) begin
            for (int k = 0; k < 4; k++) begin
                b = 8'(words[i] >> (24 - 8 * k));
                x ^= b;
                send_byte(b, pick_gap(maxgap));
            end
        end
        send_byte(x ^ cdelta, pick_gap(maxgap));
        chk({tag, "_nwr"}, got_addr.size(), words.size());
        foreach (words[i]) begin
            if (i < got_addr.size()) begin
                chk({tag, "_addr"}, got_addr[i], i % (1 << AW));
                chk({tag, "_data"}, got_data[i], words[i]);
            end
        end
        chk({tag, "_stall"}, stalls - s0, 0);
        chk({tag, "_run"}, run, (cdelta == 8'h00));
        chk({tag, "_err"}, err, (cdelta != 8'h00));
    endtask

    task automatic frame(input logic [7:0] hdr, input logic [7:0] cdelta,
                         input int maxgap, input string tag);
        send_byte(hdr, pick_gap(maxgap));
        chk({tag, "_hdr_err"}, err, 1'b0);
        body(cdelta, maxgap, tag);
    endtask

    task automatic end_run(input string tag);
        trap = 1'b1;
        tick();
        trap = 1'b0;
        chk({tag, "_trap_run"}, run, 1'b0);
        chk({tag, "_trap_done"}, done, 1'b1);
        chk({tag, "_trap_rdy"}, in_ready, 1'b1);
        tick();
        chk({tag, "_done_pulse"}, done, 1'b0);
    endtask

    initial begin
        #2;
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_run", run, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_we", imem_we, 1'b0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();

        trap = 1'b1;
        tick();
        trap = 1'b0;
        chk("idle_trap_done", done, 1'b0);
        chk("idle_trap_run", run, 1'b0);

        // One word, check write latency and run release.
        got_addr.delete();
        we0 = we_count;
        send_byte(8'h01, 0);
        send_byte(8'h10, 0);
        send_byte(8'h20, 0);
        send_byte(8'h30, 0);
        send_byte(8'h40, 0);
        chk("t1_we", imem_we, 1'b1);
        chk("t1_addr", imem_addr, 0);
        chk("t1_wdata", imem_wdata, 32'h10203040);
        tick();
        chk("t1_we_once", imem_we, 1'b0);
        chk("t1_csum_run", run, 1'b0);
        send_byte(8'h40, 0);
        chk("t1_run", run, 1'b1);
        chk("t1_nwr", we_count - we0, 1);
        end_run("t1");

        words = '{32'hDEADBEEF, 32'h00000001};
        frame(8'h02, 8'h00, 0, "t2");
        end_run("t2");

        // Bad checksum, then restart from ERR.
        words = '{32'h10203040};
        frame(8'h01, 8'h01, 0, "t3");
        we0 = we_count;
        repeat (3) tick();
        chk("t3_err_hold", err, 1'b1);
        chk("t3_run_hold", run, 1'b0);
        chk("t3_no_wr", we_count - we0, 0);
        send_byte(8'h01, 0);
        chk("t3_err_clr", err, 1'b0);
        words = '{$urandom()};
        body(8'h00, 0, "t3b");

        // Stalled byte waits in RUN and becomes the next header.
        in_valid = 1'b1;
        in_data  = 8'h02;
        repeat (3) tick();
        chk("t4_stall_rdy", in_ready, 1'b0);
        chk("t4_stall_run", run, 1'b1);
        trap = 1'b1;
        tick();
        trap = 1'b0;
        chk("t4_run", run, 1'b0);
        chk("t4_done", done, 1'b1);
        chk("t4_rdy", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t4_done_pulse", done, 1'b0);
        words = '{$urandom(), $urandom()};
        body(8'h00, 0, "t4");
        end_run("t4");

        words = '{$urandom(), $urandom(), $urandom(), $urandom()};
        frame(8'h00, 8'h00, 3, "t5");
        end_run("t5");

        for (int f = 0; f < 8; f++) begin
            int n = int'($urandom_range(1, 4));
            logic [7:0] cd = 8'h00;
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom());
            if ($urandom_range(0, 3) == 0) cd = 8'($urandom_range(1, 255));
            frame((n == 4) ? 8'h00 : 8'(n), cd, 2, "rnd");
            if (cd == 8'h00) end_run("rnd");
        end

        // Reset in the middle of a word.
        send_byte(8'h01, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_run", run, 1'b0);
        chk("t6_we", imem_we, 1'b0);
        chk("t6_err", err, 1'b0);
        chk("t6_done", done, 1'b0);
        chk("t6_rdy", in_ready, 1'b1);
        chk("t6_wdata", imem_wdata, 0);
        we0 = we_count;
        repeat (2) tick();
        chk("t6_no_wr", we_count - we0, 0);
        rst_n = 1'b1;
        repeat (3) tick();
        words = '{$urandom()};
        frame(8'h01, 8'h00, 0, "t6");
        end_run("t6");

        chk("timeouts", timeouts, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
